// File: rtl/mem_bus_pkg.sv
// Shared definitions for the core data-port routing fabric: router FSM
// encoding, the error-response data pattern and a counter-width helper.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } route_state_e;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    // Ceiling log2, never below 1 so every counter keeps at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        while ((32'd1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-cycle counter for a bus transaction; flags the cycle in which the
// TIMEOUT-th enabled cycle is being spent.
module bus_timeout_ctr
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned   CW   = clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is only ever updated with <=, so every flop samples
    // the values of the previous cycle regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/mem_route_1x2.sv
// One-outstanding load/store router: the core's data port fans out to the
// data RAM (target 0) or MMIO (target 1), with a timeout error response.
module mem_route_1x2
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] SPLIT_ADDR = 32'h0001_0000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    input  logic [3:0]  i_wstrb,
    output logic        i_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] i_rsp_rdata,
    output logic        i_rsp_err,
    output logic        i_rsp_sel,
    output logic        t0_req_valid,
    input  logic        t0_req_ready,
    output logic [31:0] t0_addr,
    output logic [31:0] t0_wdata,
    output logic        t0_we,
    output logic [3:0]  t0_wstrb,
    input  logic        t0_rsp_valid,
    input  logic [31:0] t0_rsp_rdata,
    output logic        t1_req_valid,
    input  logic        t1_req_ready,
    output logic [31:0] t1_addr,
    output logic [31:0] t1_wdata,
    output logic        t1_we,
    output logic [3:0]  t1_wstrb,
    input  logic        t1_rsp_valid,
    input  logic [31:0] t1_rsp_rdata
);

    route_state_e state, state_d;

    logic        req_ready_q, req_valid_q, rsp_valid_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic        we_q, sel_q, err_q;
    logic        accept, tgt_req_ready, tgt_rsp_valid, expired;
    logic [31:0] tgt_rsp_rdata;

    // The unselected target is invisible to the FSM in every state.
    assign tgt_req_ready = sel_q ? t1_req_ready  : t0_req_ready;
    assign tgt_rsp_valid = sel_q ? t1_rsp_valid  : t0_rsp_valid;
    assign tgt_rsp_rdata = sel_q ? t1_rsp_rdata  : t0_rsp_rdata;
    assign accept        = (state == ST_IDLE) && req_ready_q && i_req_valid;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != ST_WAIT),
        .en      (state == ST_WAIT),
        .expired (expired)
    );

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (accept)                   state_d = ST_REQ;
            ST_REQ:  if (tgt_req_ready)            state_d = ST_WAIT;
            ST_WAIT: if (tgt_rsp_valid || expired) state_d = ST_RSP;
            ST_RSP:  if (i_rsp_ready)              state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b0;
            req_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state       <= state_d;
            req_ready_q <= (state_d == ST_IDLE);
            req_valid_q <= (state_d == ST_REQ);
            rsp_valid_q <= (state_d == ST_RSP);
        end
    end

    // NOTE: the datapath registers are reset because they drive outputs that
    // must read zero during reset; plain storage would not need it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            sel_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
                we_q    <= i_we;
                wstrb_q <= i_wstrb;
                sel_q   <= (i_addr >= SPLIT_ADDR);
            end
            // A response in the timeout cycle takes priority over the error.
            if (state == ST_WAIT) begin
                if (tgt_rsp_valid) begin
                    rdata_q <= tgt_rsp_rdata;
                    err_q   <= 1'b0;
                end else if (expired) begin
                    rdata_q <= BUS_ERR_DATA;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign i_req_ready  = req_ready_q;
    assign i_rsp_valid  = rsp_valid_q;
    assign i_rsp_rdata  = rdata_q;
    assign i_rsp_err    = err_q;
    assign i_rsp_sel    = sel_q;

    assign t0_req_valid = req_valid_q && !sel_q;
    assign t1_req_valid = req_valid_q &&  sel_q;
    assign t0_addr      = addr_q;
    assign t0_wdata     = wdata_q;
    assign t0_we        = we_q;
    assign t0_wstrb     = wstrb_q;
    assign t1_addr      = addr_q;
    assign t1_wdata     = wdata_q;
    assign t1_we        = we_q;
    assign t1_wstrb     = wstrb_q;

endmodule

// File: tb/tb_mem_route_1x2.sv
// Self-checking bench for mem_route_1x2: directed scenarios plus randomized
// transactions compared against a per-transaction reference model.
`timescale 1ns/1ps
module tb_mem_route_1x2;

    localparam int unsigned TIMEOUT    = 4;
    localparam logic [31:0] SPLIT_ADDR = 32'h0001_0000;
    localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid, i_req_ready, i_we, i_rsp_valid, i_rsp_ready;
    logic        i_rsp_err, i_rsp_sel;
    logic [31:0] i_addr, i_wdata, i_rsp_rdata;
    logic [3:0]  i_wstrb;
    logic        t0_req_valid, t0_req_ready, t0_we, t0_rsp_valid;
    logic        t1_req_valid, t1_req_ready, t1_we, t1_rsp_valid;
    logic [31:0] t0_addr, t0_wdata, t0_rsp_rdata, t1_addr, t1_wdata, t1_rsp_rdata;
    logic [3:0]  t0_wstrb, t1_wstrb;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_route_1x2 #(
        .SPLIT_ADDR (SPLIT_ADDR),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (i_req_valid),
        .i_req_ready  (i_req_ready),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_we         (i_we),
        .i_wstrb      (i_wstrb),
        .i_rsp_valid  (i_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .i_rsp_rdata  (i_rsp_rdata),
        .i_rsp_err    (i_rsp_err),
        .i_rsp_sel    (i_rsp_sel),
        .t0_req_valid (t0_req_valid),
        .t0_req_ready (t0_req_ready),
        .t0_addr      (t0_addr),
        .t0_wdata     (t0_wdata),
        .t0_we        (t0_we),
        .t0_wstrb     (t0_wstrb),
        .t0_rsp_valid (t0_rsp_valid),
        .t0_rsp_rdata (t0_rsp_rdata),
        .t1_req_valid (t1_req_valid),
        .t1_req_ready (t1_req_ready),
        .t1_addr      (t1_addr),
        .t1_wdata     (t1_wdata),
        .t1_we        (t1_we),
        .t1_wstrb     (t1_wstrb),
        .t1_rsp_valid (t1_rsp_valid),
        .t1_rsp_rdata (t1_rsp_rdata)
    );

    // View of the selected / unselected target for the transaction in flight.
    logic        cur_sel = 1'b0;
    logic        s_req_valid, o_req_valid, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    assign s_req_valid = cur_sel ? t1_req_valid : t0_req_valid;
    assign o_req_valid = cur_sel ? t0_req_valid : t1_req_valid;
    assign s_addr      = cur_sel ? t1_addr      : t0_addr;
    assign s_wdata     = cur_sel ? t1_wdata     : t0_wdata;
    assign s_we        = cur_sel ? t1_we        : t0_we;
    assign s_wstrb     = cur_sel ? t1_wstrb     : t0_wstrb;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: a response delivered w WAIT cycles after the target
    // handshake wins if w <= TIMEOUT; otherwise the error response appears
    // after exactly TIMEOUT cycles.
    task automatic ref_response(input int w, input logic [31:0] d,
                                output int lat, output logic err, output logic [31:0] rdata);
        if (w <= int'(TIMEOUT)) begin
            lat = w; err = 1'b0; rdata = d;
        end else begin
            lat = int'(TIMEOUT); err = 1'b1; rdata = ERR_DATA;
        end
    endtask

    task automatic drive_rsp(input logic t, input logic v, input logic [31:0] d);
        if (t) begin t1_rsp_valid = v; t1_rsp_rdata = d; end
        else   begin t0_rsp_valid = v; t0_rsp_rdata = d; end
    endtask

    task automatic drive_ready(input logic t, input logic v);
        if (t) t1_req_ready = v;
        else   t0_req_ready = v;
    endtask

    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int rdy_dly, input int w,
                          input logic [31:0] rsp_data, input int rr_dly,
                          input bit spurious, input bit hs_rsp, input bit late_rsp);
        logic        sel;
        logic        err;
        logic [31:0] exp_rdata;
        int          lat;
        int          guard;
        int          late_c;
        sel = (addr >= SPLIT_ADDR);
        ref_response(w, rsp_data, lat, err, exp_rdata);
        late_c = (rr_dly < 2) ? rr_dly : 2;
        guard = 0;
        while (i_req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_idle", 32'(i_req_ready), 1);
        cur_sel     = sel;
        i_req_valid = 1'b1;
        i_addr      = addr;
        i_wdata     = wdata;
        i_we        = we;
        i_wstrb     = wstrb;
        @(negedge clk);
        i_req_valid = 1'b0;
        i_addr      = $urandom;
        i_wdata     = $urandom;
        i_we        = 1'($urandom);
        i_wstrb     = 4'($urandom);
        for (int c = 0; c <= rdy_dly; c++) begin
            check("req_valid_sel",   32'(s_req_valid), 1);
            check("req_valid_other", 32'(o_req_valid), 0);
            check("req_addr",        s_addr, addr);
            check("req_wdata",       s_wdata, wdata);
            check("req_we",          32'(s_we), 32'(we));
            check("req_wstrb",       32'(s_wstrb), 32'(wstrb));
            check("req_ready_busy",  32'(i_req_ready), 0);
            drive_ready(sel, c == rdy_dly);
            if (c == rdy_dly && hs_rsp) drive_rsp(sel, 1'b1, $urandom);
            @(negedge clk);
        end
        drive_ready(sel, 1'b0);
        drive_rsp(sel, 1'b0, '0);
        for (int j = 1; j <= lat; j++) begin
            check("wait_no_rsp",    32'(i_rsp_valid), 0);
            check("wait_req_valid", 32'(s_req_valid | o_req_valid), 0);
            drive_rsp(sel, j == w, (j == w) ? rsp_data : $urandom);
            if (spurious) drive_rsp(!sel, 1'($urandom_range(0, 1)), $urandom);
            @(negedge clk);
        end
        drive_rsp(sel, 1'b0, '0);
        drive_rsp(!sel, 1'b0, '0);
        for (int c = 0; c <= rr_dly; c++) begin
            check("rsp_valid",      32'(i_rsp_valid), 1);
            check("rsp_rdata",      i_rsp_rdata, exp_rdata);
            check("rsp_err",        32'(i_rsp_err), 32'(err));
            check("rsp_sel",        32'(i_rsp_sel), 32'(sel));
            check("rsp_req_ready",  32'(i_req_ready), 0);
            i_rsp_ready = (c == rr_dly);
            drive_rsp(sel, late_rsp && (c == late_c), $urandom);
            @(negedge clk);
        end
        i_rsp_ready = 1'b0;
        drive_rsp(sel, 1'b0, '0);
        check("rsp_done",       32'(i_rsp_valid), 0);
        check("req_ready_back", 32'(i_req_ready), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(i_req_ready), 0);
        check({tag, "_rsp_valid"}, 32'(i_rsp_valid), 0);
        check({tag, "_rsp_err"},   32'(i_rsp_err), 0);
        check({tag, "_rsp_sel"},   32'(i_rsp_sel), 0);
        check({tag, "_rsp_rdata"}, i_rsp_rdata, 0);
        check({tag, "_t_valid"},   32'({t0_req_valid, t1_req_valid}), 0);
        check({tag, "_t_addr"},    t0_addr | t1_addr, 0);
        check({tag, "_t_wdata"},   t0_wdata | t1_wdata, 0);
        check({tag, "_t_ctl"},     32'({t0_we, t1_we, t0_wstrb, t1_wstrb}), 0);
    endtask

    task automatic reset_in_wait();
        cur_sel     = 1'b1;
        i_req_valid = 1'b1;
        i_addr      = 32'h0002_0010;
        i_wdata     = 32'hCAFE_F00D;
        i_we        = 1'b1;
        i_wstrb     = 4'hF;
        @(negedge clk);
        i_req_valid = 1'b0;
        drive_ready(1'b1, 1'b1);
        @(negedge clk);
        drive_ready(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        drive_rsp(1'b1, 1'b1, 32'h5555_AAAA);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready_low", 32'(i_req_ready), 0);
        @(negedge clk);
        check("rel_ready_high", 32'(i_req_ready), 1);
        drive_rsp(1'b1, 1'b0, '0);
        repeat (3) begin
            check("rel_no_stale_rsp", 32'(i_rsp_valid), 0);
            check("rel_no_req",       32'(t0_req_valid | t1_req_valid), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        i_req_valid  = 1'b0;
        i_addr       = '0;
        i_wdata      = '0;
        i_we         = 1'b0;
        i_wstrb      = '0;
        i_rsp_ready  = 1'b0;
        t0_req_ready = 1'b0;
        t1_req_ready = 1'b0;
        t0_rsp_valid = 1'b0;
        t1_rsp_valid = 1'b0;
        t0_rsp_rdata = '0;
        t1_rsp_rdata = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("post_rst_ready_low", 32'(i_req_ready), 0);
        @(negedge clk);
        check("post_rst_ready_high", 32'(i_req_ready), 1);

        // addr, we, wdata, wstrb, rdy_dly, w, rsp_data, rr_dly, spurious, hs_rsp, late_rsp
        do_txn(32'h0000_0040, 1'b0, 32'h0,         4'h0, 0, 1, 32'h1234_5678, 0, 0, 0, 0);
        do_txn(32'h0001_0000, 1'b1, 32'hA5A5_0F0F, 4'h3, 3, 2, 32'h0BAD_0001, 0, 0, 0, 0);
        do_txn(32'h0001_0040, 1'b0, 32'h0,         4'h0, 0, TIMEOUT + 2, 32'h7777_7777, 3, 0, 0, 1);
        do_txn(32'h0001_0044, 1'b0, 32'h0,         4'h0, 0, 1, 32'h2468_ACE0, 0, 0, 0, 0);
        do_txn(32'h0000_1000, 1'b0, 32'h0,         4'h0, 1, 2, 32'h1357_9BDF, 5, 0, 0, 0);
        do_txn(32'h8000_0000, 1'b0, 32'h0,         4'h0, 0, TIMEOUT, 32'hFACE_B00C, 0, 1, 0, 0);
        do_txn(32'h0000_FFFF, 1'b1, 32'h0102_0304, 4'hC, 2, 3, 32'h0000_0000, 1, 1, 0, 0);
        do_txn(32'h0000_0200, 1'b0, 32'h0,         4'h0, 0, 2, 32'h3C3C_3C3C, 0, 0, 1, 0);

        reset_in_wait();

        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a = $urandom_range(0, 1) ? $urandom_range(0, 32'h0001_FFFF) : $urandom;
            do_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
                   $urandom_range(1, TIMEOUT + 2), $urandom, $urandom_range(0, 4),
                   1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_route_1x2.md
# mem_route_1x2

Single-initiator, two-target load/store router for the core's data port. It accepts one request from the core and forwards it to target 0 (data RAM) or target 1 (MMIO), selected by address. It then returns the selected target's response, or a timeout error response, to the core. One transaction is outstanding at a time; all request and response fields are registered. It sits between the MEM stage and the memory/peripheral slaves, as the fan-out counterpart of the writeback/read-data select muxes.

## Interface
- SPLIT_ADDR, 32'h0001_0000: unsigned address boundary; addr >= SPLIT_ADDR routes to target 1, else target 0.
- TIMEOUT, 255: cycles spent in WAIT without a response before an error response is generated; legal range 1..65535.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  core request valid.
- i_req_ready  out  1  router can accept a request.
- i_addr  in  32  byte address.
- i_wdata  in  32  write data.
- i_we  in  1  1 = store, 0 = load.
- i_wstrb  in  4  byte enables (stores).
- i_rsp_valid  out  1  response to core valid.
- i_rsp_ready  in  1  core accepts response.
- i_rsp_rdata  out  32  load data (don't-care content for stores, passed through).
- i_rsp_err  out  1  1 = timeout response.
- i_rsp_sel  out  1  target that served (or timed out) the transaction.
- tN_req_valid  out  1  request valid to target N (N = 0, 1).
- tN_req_ready  in  1  target N accepts request.
- tN_addr / tN_wdata / tN_we / tN_wstrb  out  32/32/1/4  latched request fields to target N.
- tN_rsp_valid  in  1  target N response (single-cycle pulse, no backpressure).
- tN_rsp_rdata  in  32  target N response data.

## Operation
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE:
  - i_req_ready = 1.
  - On i_req_valid: latch addr, wdata, we, wstrb and sel = (i_addr >= SPLIT_ADDR); go to REQ.
- REQ:
  - t[sel]_req_valid = 1 with the latched fields; the other target's valid is 0.
  - Fields are held stable until t[sel]_req_ready; then go to WAIT and clear the counter.
- WAIT:
  - The counter increments each cycle.
  - If t[sel]_rsp_valid: capture rdata, err = 0, go to RSP.
  - Else if counter == TIMEOUT-1: rdata = 32'hDEAD_BEEF, err = 1, go to RSP.
  - If the response and the timeout coincide, the response wins.
- RSP:
  - i_rsp_valid = 1; rdata, err and sel are held stable.
  - On i_rsp_ready go to IDLE.
- Ignored inputs:
  - The unselected target's rsp_valid is ignored in every state.
  - tN_rsp_valid outside WAIT is ignored, including a late response after a timeout and a response in the request-handshake cycle.
- Stores produce a response exactly like loads.

## Timing
- Reset (asynchronous, rst_n low):
  - State is IDLE.
  - Every output is 0: i_req_ready, i_rsp_valid, i_rsp_err, i_rsp_sel, i_rsp_rdata, tN_req_valid and all tN fields.
  - i_req_ready is registered. It is 0 during reset and 1 from the first rising edge after release.
- Minimum latency:
  - Accept at edge N.
  - tS_req_valid is high during cycle N+1; handshake at edge N+1.
  - Response sampled in WAIT at edge N+2.
  - i_rsp_valid is high from cycle N+3.
- Throughput: at most one transaction per 4 cycles. i_req_ready is low from acceptance until the cycle after the i_rsp handshake.
- Timeout: exactly TIMEOUT cycles are spent in WAIT. i_rsp_valid rises TIMEOUT+1 cycles after the target handshake.
- Reset mid-transaction: the transaction is abandoned and no response is issued. A target response arriving after reset is ignored.

## Structure
- Shared package/include mem_bus_pkg:
  - FSM state encoding (2-bit).
  - BUS_ERR_DATA = 32'hDEAD_BEEF.
  - A clog2 helper for counter width.
- One sub-module, bus_timeout_ctr:
  - Parameter TIMEOUT.
  - Inputs clk, rst_n, clr, en.
  - Output expired = (count == TIMEOUT-1) && en.
  - Counter width is clog2(TIMEOUT+1).
- Everything else (FSM, latches, select compare) is in mem_route_1x2.

## Test plan
- Load 0x0000_0040, t0 ready immediately, rsp 0x1234_5678 one cycle later -> t1 untouched; i_rsp_valid at N+3 with rdata 0x1234_5678, err 0, sel 0.
- Store 0x0001_0000 (exact boundary), wstrb 4'b0011, t1 ready after 3 cycles -> t1_req_valid held 3 cycles with stable fields; response sel 1, err 0.
- Load to t1, no response, TIMEOUT = 4 -> after 4 WAIT cycles, i_rsp_valid with rdata 0xDEAD_BEEF, err 1. A t1 rsp arriving 2 cycles later is ignored and the next transaction is unaffected.
- Response with i_rsp_ready low for 5 cycles -> i_rsp_valid and all fields held; i_req_ready stays 0 until the handshake; a new request is accepted the following cycle.
- Spurious t0_rsp_valid while serving t1, and rsp coinciding with the timeout cycle -> spurious pulse ignored; coincident response returned with err 0.
- rst_n asserted in WAIT -> all outputs 0 immediately; i_req_ready = 1 on the first edge after release; no stale response is emitted.
